// File: rtl/pipo_pipe.sv
// Parallel-in/parallel-out register pipeline with per-stage valid bits, stall and flush.
// Optional occupancy counter output enabled by defining PIPO_PIPE_OCC_EN.
module pipo_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             hold,
  input  logic             clr,
  output logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld
`ifdef PIPO_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic             adv;

  assign adv = ~hold & ~clr;
  assign rdy = ~hold;

  // Data registers: a stage only loads when a valid word arrives, so bubbles keep old data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
    end else if (adv) begin
      if (ld) data_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  // Valid bits: flushed by rst or clr, frozen by hold, otherwise shifted with ld entering
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_p <= '0;
    end else if (!hold) begin
      vld_p[0] <= ld;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign dout     = data_p[DEPTH-1];
  assign dout_vld = vld_p[DEPTH-1];

`ifdef PIPO_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);
  logic [OCC_W-1:0] occ_q;

  // One word may enter and one may leave per advance, so the count moves by at most 1
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      occ_q <= '0;
    end else if (!hold) begin
      occ_q <= occ_q + OCC_W'(ld) - OCC_W'(vld_p[DEPTH-1]);
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipo_pipe.sv
// Bench for pipo_pipe (WIDTH=16, DEPTH=3): per-cycle vector table plus an ordering scoreboard.
module tb_pipo_pipe;

  logic        clk = 1'b0;
  logic        rst, ld, hold, clr;
  logic [15:0] din;
  logic        rdy, dout_vld;
  logic [15:0] dout;
`ifdef PIPO_PIPE_OCC_EN
  logic [1:0]  occ;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] sb [$];

  typedef struct {
    logic        rst, clr, hold, ld;
    logic [15:0] din;
    logic        vld;
    logic [15:0] dout;
    int          occ;
  } vec_t;
  vec_t tbl [$];

  pipo_pipe #(.WIDTH(16), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .ld(ld), .din(din), .hold(hold), .clr(clr),
    .rdy(rdy), .dout(dout), .dout_vld(dout_vld)
`ifdef PIPO_PIPE_OCC_EN
    , .occ(occ)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check rdy before the edge, update the scoreboard after it.
  task automatic cycle(input logic r, input logic c, input logic h, input logic l,
                       input logic [15:0] d);
    logic [15:0] exp_w;
    rst = r; clr = c; hold = h; ld = l; din = d;
    #1;
    check("rdy", {63'd0, rdy}, {63'd0, ~h});
    @(posedge clk);
    #1;
    if (r || c) sb.delete();
    else if (!h && l) sb.push_back(d);
    if (!r && !c && !h && dout_vld) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_order: dout_vld with dout=0x%0h, expected no output word", dout);
      end else begin
        exp_w = sb.pop_front();
        check("sb_dout", {48'd0, dout}, {48'd0, exp_w});
      end
    end
  endtask

  task automatic add(input logic r, input logic c, input logic h, input logic l,
                     input logic [15:0] d, input logic v, input logic [15:0] o, input int n);
    vec_t e;
    e.rst = r; e.clr = c; e.hold = h; e.ld = l; e.din = d;
    e.vld = v; e.dout = o; e.occ = n;
    tbl.push_back(e);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; hold = 1'b0; ld = 1'b0; din = '0;

    //   rst clr hold ld din       vld dout     occ
    add(1, 0, 0, 0, 16'h0000,  0, 16'h0000, 0);   // reset state
    add(0, 0, 0, 1, 16'h0001,  0, 16'h0000, 1);   // stream
    add(0, 0, 0, 1, 16'h0002,  0, 16'h0000, 2);
    add(0, 0, 0, 1, 16'h0003,  1, 16'h0001, 3);
    add(0, 0, 0, 0, 16'h0000,  1, 16'h0002, 2);
    add(0, 0, 0, 0, 16'h0000,  1, 16'h0003, 1);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h0003, 0);   // dout retained
    add(0, 0, 0, 1, 16'hAAAA,  0, 16'h0003, 1);   // stall
    for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 16'h5555, 0, 16'h0003, 1);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h0003, 1);
    add(0, 0, 0, 0, 16'h0000,  1, 16'hAAAA, 1);
    add(0, 0, 0, 0, 16'h0000,  0, 16'hAAAA, 0);
    add(0, 0, 0, 1, 16'h1111,  0, 16'hAAAA, 1);   // bubble
    add(0, 0, 0, 0, 16'hFFFF,  0, 16'hAAAA, 1);
    add(0, 0, 0, 1, 16'h2222,  1, 16'h1111, 2);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h1111, 1);
    add(0, 0, 0, 0, 16'h0000,  1, 16'h2222, 1);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h2222, 0);
    add(0, 0, 0, 1, 16'h0A01,  0, 16'h2222, 1);   // flush
    add(0, 0, 0, 1, 16'h0A02,  0, 16'h2222, 2);
    add(0, 0, 0, 1, 16'h0A03,  1, 16'h0A01, 3);
    add(0, 1, 0, 1, 16'h7777,  0, 16'h0A01, 0);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h0A01, 0);
    add(0, 0, 0, 1, 16'h0B01,  0, 16'h0A01, 1);   // reset mid-stream
    add(0, 0, 0, 1, 16'h0B02,  0, 16'h0A01, 2);
    add(1, 0, 0, 1, 16'h0C0C,  0, 16'h0000, 0);
    add(0, 0, 0, 1, 16'h1234,  0, 16'h0000, 1);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1);
    add(0, 0, 0, 0, 16'h0000,  1, 16'h1234, 1);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h1234, 0);
    add(0, 0, 0, 1, 16'h0D01,  0, 16'h1234, 1);   // simultaneous events
    add(0, 0, 0, 1, 16'h0D02,  0, 16'h1234, 2);
    add(0, 0, 0, 1, 16'h0D03,  1, 16'h0D01, 3);
    add(1, 1, 1, 1, 16'h0E0E,  0, 16'h0000, 0);
    add(0, 0, 0, 1, 16'h0D04,  0, 16'h0000, 1);
    add(0, 0, 0, 1, 16'h0D05,  0, 16'h0000, 2);
    add(0, 0, 0, 1, 16'h0D06,  1, 16'h0D04, 3);
    add(0, 1, 1, 1, 16'h0E0E,  0, 16'h0D04, 0);
    add(0, 0, 0, 0, 16'h0000,  0, 16'h0D04, 0);

    @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      cycle(tbl[k].rst, tbl[k].clr, tbl[k].hold, tbl[k].ld, tbl[k].din);
      check($sformatf("vec%0d_vld", k), {63'd0, dout_vld}, {63'd0, tbl[k].vld});
      check($sformatf("vec%0d_dout", k), {48'd0, dout}, {48'd0, tbl[k].dout});
`ifdef PIPO_PIPE_OCC_EN
      check($sformatf("vec%0d_occ", k), {62'd0, occ}, 64'(tbl[k].occ));
`endif
    end

    // Random traffic with stalls, flushes and resets; ordering checked by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 41) == 0, ($urandom % 23) == 0, ($urandom % 5) == 0,
            ($urandom % 4) != 0, 16'($urandom));
    end
    for (int n = 0; n < 5; n++) cycle(0, 0, 0, 0, 16'h0000);
    check("drain_left", 64'(sb.size()), 64'd0);
    check("drain_vld", {63'd0, dout_vld}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
